key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_if.sv | 26 ++
 rtl/key_debounce_sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 108 ++++++++++
 tb/tb_key_debounce.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      UP      = 2'd0,
      WAIT_DN = 2'd1,
      DOWN    = 2'd2,
      WAIT_UP = 2'd3
   } db_state_t;

   // 20 samples of a 1 ms tick gives a 20 ms qualification window.
   localparam int unsigned STABLE_CNT_DEFAULT = 20;

endpackage

// File: rtl/key_debounce_if.sv
// Sample strobe, raw key and debounced outputs bundled between producer and debouncer.
interface key_debounce_if;

   logic tick;
   logic key_in;
   logic key_level;
   logic key_press;
   logic key_release;

   modport master (
      output tick,
      output key_in,
      input  key_level,
      input  key_press,
      input  key_release
   );

   modport slave (
      input  tick,
      input  key_in,
      output key_level,
      output key_press,
      output key_release
   );

endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit board inputs.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic q1;

   // Two back-to-back flops; the reset value lets each user pick its idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1 <= RST_VAL;
         q  <= RST_VAL;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: tick-sampled qualification with level and edge pulses.
//
// state   | meaning
// --------+------------------------------------------------------------
// UP      | key released and accepted as released
// WAIT_DN | pressed samples seen, counting toward accepting a press
// DOWN    | key pressed and accepted as pressed
// WAIT_UP | released samples seen, counting toward accepting a release
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = STABLE_CNT_DEFAULT,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   key_debounce_if.slave bus
);

   // cnt is compared against the last sample index, so it tops out at STABLE_CNT-1.
   localparam logic [7:0] LAST_IDX = 8'(STABLE_CNT - 1);

   db_state_t  state;
   logic [7:0] cnt;
   logic       sync_q2;
   logic       pressed_s;
   logic       level_q;
   logic       press_q;
   logic       release_q;

   sync_2ff #(
      .RST_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.key_in),
      .q     (sync_q2)
   );

   assign pressed_s = sync_q2 ^ ACTIVE_LOW;

   // Debounce FSM: advances only on tick cycles; pulses clear on the next clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= UP;
         cnt       <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (bus.tick) begin
            case (state)
               UP: begin
                  if (pressed_s) begin
                     state <= WAIT_DN;
                     cnt   <= 8'd1;
                  end else begin
                     cnt <= '0;
                  end
               end
               WAIT_DN: begin
                  if (!pressed_s) begin
                     state <= UP;
                     cnt   <= '0;
                  end else if (cnt == LAST_IDX) begin
                     state   <= DOWN;
                     cnt     <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               DOWN: begin
                  if (!pressed_s) begin
                     state <= WAIT_UP;
                     cnt   <= 8'd1;
                  end
               end
               WAIT_UP: begin
                  if (pressed_s) begin
                     state <= DOWN;
                     cnt   <= '0;
                  end else if (cnt == LAST_IDX) begin
                     state     <= UP;
                     cnt       <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               default: begin
                  state <= UP;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.key_level   = level_q;
   assign bus.key_press   = press_q;
   assign bus.key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (STABLE_CNT=4, active-low key).
module tb_key_debounce;

   localparam int STABLE = 4;

   typedef struct {
      logic key;
      int   nticks;
      logic exp_level;
      int   exp_press;
      int   exp_release;
   } phase_t;

   logic clk;
   logic rst_n;

   key_debounce_if bus ();

   key_debounce #(
      .STABLE_CNT (STABLE),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: run length of samples that disagree with the accepted level.
   logic [1:0] m_sync;
   logic       m_level;
   logic       m_press;
   logic       m_release;
   int         m_run;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sync    <= 2'b11;
         m_level   <= 1'b0;
         m_press   <= 1'b0;
         m_release <= 1'b0;
         m_run     <= 0;
      end else begin
         m_sync    <= {m_sync[0], bus.key_in};
         m_press   <= 1'b0;
         m_release <= 1'b0;
         if (bus.tick) begin
            if ((!m_sync[1]) != m_level) begin
               if (m_run + 1 == STABLE) begin
                  m_level   <= !m_level;
                  m_run     <= 0;
                  m_press   <= !m_level;
                  m_release <= m_level;
               end else begin
                  m_run <= m_run + 1;
               end
            end else begin
               m_run <= 0;
            end
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;
   int press_seen;
   int release_seen;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: compare outputs at the falling edge, then drive the next inputs.
   task automatic cyc(input logic k, input logic t);
      @(negedge clk);
      chk("level_vs_model", int'(bus.key_level), int'(m_level));
      chk("press_vs_model", int'(bus.key_press), int'(m_press));
      chk("release_vs_model", int'(bus.key_release), int'(m_release));
      chk("press_release_exclusive", int'(bus.key_press & bus.key_release), 0);
      press_seen   += int'(bus.key_press);
      release_seen += int'(bus.key_release);
      bus.key_in = k;
      bus.tick   = t;
   endtask

   // n tick samples of level k, one tick every 5th clock, mid-window so the synchronizer has settled.
   task automatic run_ticks(input logic k, input int n);
      for (int i = 0; i < n; i++) begin
         cyc(k, 1'b0);
         cyc(k, 1'b0);
         cyc(k, 1'b1);
         cyc(k, 1'b0);
         cyc(k, 1'b0);
      end
   endtask

   task automatic phase(input string name, input phase_t p);
      press_seen   = 0;
      release_seen = 0;
      run_ticks(p.key, p.nticks);
      chk({name, "_level"}, int'(bus.key_level), int'(p.exp_level));
      chk({name, "_press_count"}, press_seen, p.exp_press);
      chk({name, "_release_count"}, release_seen, p.exp_release);
   endtask

   phase_t vec[10];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic k;
      int   hold;

      vec[0] = '{key: 1'b0, nticks: 3, exp_level: 1'b0, exp_press: 0, exp_release: 0};
      vec[1] = '{key: 1'b0, nticks: 1, exp_level: 1'b1, exp_press: 1, exp_release: 0};
      vec[2] = '{key: 1'b1, nticks: 3, exp_level: 1'b1, exp_press: 0, exp_release: 0};
      vec[3] = '{key: 1'b1, nticks: 1, exp_level: 1'b0, exp_press: 0, exp_release: 1};
      vec[4] = '{key: 1'b0, nticks: 3, exp_level: 1'b0, exp_press: 0, exp_release: 0};
      vec[5] = '{key: 1'b1, nticks: 1, exp_level: 1'b0, exp_press: 0, exp_release: 0};
      vec[6] = '{key: 1'b0, nticks: 3, exp_level: 1'b0, exp_press: 0, exp_release: 0};
      vec[7] = '{key: 1'b0, nticks: 1, exp_level: 1'b1, exp_press: 1, exp_release: 0};
      vec[8] = '{key: 1'b1, nticks: 4, exp_level: 1'b0, exp_press: 0, exp_release: 1};
      vec[9] = '{key: 1'b0, nticks: 2, exp_level: 1'b0, exp_press: 0, exp_release: 0};

      rst_n      = 1'b0;
      bus.key_in = 1'b0;
      bus.tick   = 1'b0;
      press_seen   = 0;
      release_seen = 0;

      // Reset held with the key pressed: everything stays low.
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
      chk("reset_level", int'(bus.key_level), 0);
      chk("reset_press", int'(bus.key_press), 0);
      chk("reset_release", int'(bus.key_release), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.tick = 1'b0;

      // Press, release, bounce and re-press sequences; ends in WAIT_DN with two samples.
      for (int i = 0; i < 10; i++) phase($sformatf("phase%0d", i), vec[i]);

      // Tick gated off while the key chatters: the two-sample count must survive.
      press_seen = 0;
      for (int i = 0; i < 100; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
      chk("gate_level", int'(bus.key_level), 0);
      chk("gate_press_count", press_seen, 0);
      press_seen = 0;
      run_ticks(1'b0, 2);
      chk("gate_resume_press_count", press_seen, 1);
      chk("gate_resume_level", int'(bus.key_level), 1);

      // Back to UP, then reset while two pressed samples are pending.
      run_ticks(1'b1, 4);
      run_ticks(1'b0, 2);
      rst_n = 1'b0;
      press_seen = 0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
      chk("midreset_level", int'(bus.key_level), 0);
      chk("midreset_press", int'(bus.key_press), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.tick = 1'b0;
      run_ticks(1'b0, 3);
      chk("postreset_no_early_press", press_seen, 0);
      run_ticks(1'b0, 1);
      chk("postreset_press_count", press_seen, 1);
      chk("postreset_level", int'(bus.key_level), 1);

      // Random key activity with random (sometimes back-to-back) ticks against the model.
      k    = 1'b1;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            k    = ~k;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
         end
         hold--;
         cyc(k, 1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < 4; i++) cyc(k, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
